// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries the fetch-side BTB prediction through D and E,
// checks it against the real outcome in E, and updates the BTB, BHT and statistics.
module branch_resolve_unit #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_F,
  input  logic            btb_hit_F,
  input  logic [PC_W-1:0] btb_target_F,
  input  logic            stall_D,
  input  logic            bubble_E,
  input  logic [PC_W-1:0] pc_E,
  input  logic            branch_E,
  input  logic            jump_E,
  input  logic            taken_E,
  input  logic [PC_W-1:0] target_E,
  output logic            pred_taken_F,
  output logic [PC_W-1:0] next_pc_F,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            btb_wr_en,
  output logic [PC_W-1:0] btb_wr_pc,
  output logic [PC_W-1:0] btb_wr_target,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int BHT_N = 1 << IDX_W;

  logic [1:0]      bht_q [BHT_N];
  logic            vD_q, ptD_q, vE_q, ptE_q;
  logic [PC_W-1:0] tgtD_q, tgtE_q;
  logic [31:0]     branchCnt_q, branchCnt_d, mispredCnt_q, mispredCnt_d;

  logic [IDX_W-1:0] idxF, idxE;
  logic             actual, mis, resolveUpd;
  logic [1:0]       bhtOld, bhtNew;

  assign idxF = pc_F[IDX_W+1:2];
  assign idxE = pc_E[IDX_W+1:2];

  // F reads the registered BHT only, so an update in the same cycle is not bypassed.
  assign pred_taken_F = btb_hit_F & bht_q[idxF][1];
  assign next_pc_F    = pred_taken_F ? btb_target_F : pc_F + PC_W'(4);

  always_comb begin
    actual = jump_E | (branch_E & taken_E);
    mis    = (actual != ptE_q) | (actual & ptE_q & (target_E != tgtE_q));
  end

  assign resolveUpd    = vE_q & (branch_E | jump_E);
  assign redirect      = vE_q & mis;
  assign redirect_pc   = vE_q ? (actual ? target_E : pc_E + PC_W'(4)) : '0;
  assign btb_wr_en     = vE_q & actual;
  assign btb_wr_pc     = vE_q ? pc_E : '0;
  assign btb_wr_target = vE_q ? target_E : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vD_q   <= 1'b0;
      ptD_q  <= 1'b0;
      tgtD_q <= '0;
    end else if (redirect) begin
      vD_q <= 1'b0;
    end else if (!stall_D) begin
      vD_q   <= 1'b1;
      ptD_q  <= pred_taken_F;
      tgtD_q <= btb_target_F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vE_q   <= 1'b0;
      ptE_q  <= 1'b0;
      tgtE_q <= '0;
    end else if (redirect || bubble_E) begin
      vE_q   <= 1'b0;
      ptE_q  <= 1'b0;
      tgtE_q <= '0;
    end else begin
      vE_q   <= vD_q;
      ptE_q  <= ptD_q;
      tgtE_q <= tgtD_q;
    end
  end

  // Jumps are always taken, so their entry goes straight to strongly taken.
  assign bhtOld = bht_q[idxE];
  always_comb begin
    bhtNew = bhtOld;
    if (jump_E) begin
      bhtNew = 2'b11;
    end else if (actual) begin
      if (bhtOld != 2'b11) bhtNew = bhtOld + 2'd1;
    end else if (bhtOld != 2'b00) begin
      bhtNew = bhtOld - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else if (resolveUpd) begin
      bht_q[idxE] <= bhtNew;
    end
  end

  always_comb begin
    branchCnt_d  = branchCnt_q;
    mispredCnt_d = mispredCnt_q;
    if (resolveUpd && branchCnt_q != 32'hFFFF_FFFF) branchCnt_d = branchCnt_q + 32'd1;
    if (redirect && mispredCnt_q != 32'hFFFF_FFFF) mispredCnt_d = mispredCnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branchCnt_q  <= '0;
      mispredCnt_q <= '0;
    end else begin
      branchCnt_q  <= branchCnt_d;
      mispredCnt_q <= mispredCnt_d;
    end
  end

  assign branch_cnt  = branchCnt_q;
  assign mispred_cnt = mispredCnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scenario bench for branch_resolve_unit: expected resolve results are queued at
// fetch time and popped when the instruction reaches E.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_F, btb_target_F, pc_E, target_E;
  logic        btb_hit_F, stall_D, bubble_E, branch_E, jump_E, taken_E;
  logic        pred_taken_F, redirect, btb_wr_en;
  logic [31:0] next_pc_F, redirect_pc, btb_wr_pc, btb_wr_target, branch_cnt, mispred_cnt;

  typedef struct packed {
    logic        redir;
    logic [31:0] rpc;
    logic        wr;
    logic [31:0] wpc;
    logic [31:0] wtgt;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n),
    .pc_F(pc_F), .btb_hit_F(btb_hit_F), .btb_target_F(btb_target_F),
    .stall_D(stall_D), .bubble_E(bubble_E),
    .pc_E(pc_E), .branch_E(branch_E), .jump_E(jump_E), .taken_E(taken_E), .target_E(target_E),
    .pred_taken_F(pred_taken_F), .next_pc_F(next_pc_F),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .btb_wr_en(btb_wr_en), .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Write address/target are only meaningful with the write strobe, so they are masked.
  function automatic exp_t observe();
    exp_t o;
    o.redir = redirect;
    o.rpc   = redirect_pc;
    o.wr    = btb_wr_en;
    o.wpc   = btb_wr_en ? btb_wr_pc : 32'h0;
    o.wtgt  = btb_wr_en ? btb_wr_target : 32'h0;
    return o;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearE();
    pc_E = 32'h0; branch_E = 1'b0; jump_E = 1'b0; taken_E = 1'b0; target_E = 32'h0;
  endtask

  task automatic idleInputs();
    pc_F = 32'h0; btb_hit_F = 1'b0; btb_target_F = 32'h0;
    stall_D = 1'b0; bubble_E = 1'b0;
    clearE();
  endtask

  // Fetch in cycle A, idle in B, E-stage outcome driven in C; returns just after C's
  // inputs are applied, with the F-stage prediction sampled in A.
  task automatic pipeInstr(input logic [31:0] fpc, input logic hit, input logic [31:0] ftgt,
                           input logic br, input logic jmp, input logic tk,
                           input logic [31:0] etgt,
                           output logic predObs, output logic [31:0] nextObs);
    pc_F = fpc; btb_hit_F = hit; btb_target_F = ftgt;
    @(negedge clk);
    predObs = pred_taken_F;
    nextObs = next_pc_F;
    nextCycle();
    pc_F = 32'h0; btb_hit_F = 1'b0; btb_target_F = 32'h0;
    nextCycle();
    pc_E = fpc; branch_E = br; jump_E = jmp; taken_E = tk; target_E = etgt;
  endtask

  task automatic test_reset();
    logic [31:0] pcs [4];
    pcs = '{32'h0, 32'h100, 32'h3FC, 32'hABC0};
    idleInputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pc_F = 32'h100; btb_hit_F = 1'b1; btb_target_F = 32'h200;
    @(negedge clk);
    checks++;
    if ({redirect, btb_wr_en} !== 2'b00)
      begin errors++; $display("[TB] FAIL reset_resolve: got %b expected 00", {redirect, btb_wr_en}); end
    checks++;
    if ({branch_cnt, mispred_cnt} !== 64'h0)
      begin errors++; $display("[TB] FAIL reset_counters: got %h expected 0", {branch_cnt, mispred_cnt}); end
    checks++;
    if ({pred_taken_F, next_pc_F} !== {1'b0, 32'h104})
      begin errors++; $display("[TB] FAIL reset_pred: got %h expected %h", {pred_taken_F, next_pc_F}, {1'b0, 32'h104}); end
    rst_n = 1'b1;
    foreach (pcs[i]) begin
      pc_F = pcs[i];
      #1;
      checks++;
      if (pred_taken_F !== 1'b0)
        begin errors++; $display("[TB] FAIL post_reset_pred pc=%h: got %b expected 0", pcs[i], pred_taken_F); end
    end
    idleInputs();
    nextCycle();
  endtask

  task automatic test_cold_branch();
    logic p; logic [31:0] n; exp_t e, o;
    sbq.push_back({1'b1, 32'h200, 1'b1, 32'h100, 32'h200});
    pipeInstr(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200, p, n);
    checks++;
    if ({p, n} !== {1'b0, 32'h104})
      begin errors++; $display("[TB] FAIL cold_pred: got %h expected %h", {p, n}, {1'b0, 32'h104}); end
    @(negedge clk);
    checks++; o = observe();
    if (sbq.size() == 0) begin errors++; $display("[TB] FAIL cold_resolve: got %h expected queued entry", o); end
    else begin e = sbq.pop_front(); if (o !== e) begin errors++; $display("[TB] FAIL cold_resolve: got %h expected %h", o, e); end end
    nextCycle();
    clearE();
    checks++;
    if ({branch_cnt, mispred_cnt} !== {32'd1, 32'd1})
      begin errors++; $display("[TB] FAIL cold_counters: got %h expected %h", {branch_cnt, mispred_cnt}, {32'd1, 32'd1}); end
    checks++;
    if (dut.bht_q[8'h40] !== 2'b10)
      begin errors++; $display("[TB] FAIL cold_bht: got %b expected 10", dut.bht_q[8'h40]); end
    checks++;
    if ({dut.vD_q, dut.vE_q} !== 2'b00)
      begin errors++; $display("[TB] FAIL cold_flush: got %b expected 00", {dut.vD_q, dut.vE_q}); end
  endtask

  task automatic test_warm_hit();
    logic p; logic [31:0] n; exp_t e, o;
    sbq.push_back({1'b0, 32'h200, 1'b1, 32'h100, 32'h200});
    pipeInstr(32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h200, p, n);
    checks++;
    if ({p, n} !== {1'b1, 32'h200})
      begin errors++; $display("[TB] FAIL warm_pred: got %h expected %h", {p, n}, {1'b1, 32'h200}); end
    @(negedge clk);
    checks++; o = observe();
    if (sbq.size() == 0) begin errors++; $display("[TB] FAIL warm_resolve: got %h expected queued entry", o); end
    else begin e = sbq.pop_front(); if (o !== e) begin errors++; $display("[TB] FAIL warm_resolve: got %h expected %h", o, e); end end
    nextCycle();
    clearE();
    checks++;
    if ({branch_cnt, mispred_cnt} !== {32'd2, 32'd1})
      begin errors++; $display("[TB] FAIL warm_counters: got %h expected %h", {branch_cnt, mispred_cnt}, {32'd2, 32'd1}); end
    checks++;
    if (dut.bht_q[8'h40] !== 2'b11)
      begin errors++; $display("[TB] FAIL warm_bht: got %b expected 11", dut.bht_q[8'h40]); end
  endtask

  task automatic test_wrong_target();
    logic p; logic [31:0] n; exp_t e, o;
    // Cold JAL at 0x300 to train the entry, then JALR to a different target, then a not-taken.
    logic [31:0] fpc [3], ftg [3], etg [3], expN [3];
    logic        hit [3], jmp [3], tk [3], expP [3];
    logic [1:0]  expBht [3];
    logic [7:0]  bIdx [3];
    logic [63:0] expCnt [3];
    fpc = '{32'h300, 32'h300, 32'h100}; ftg = '{32'h0, 32'h400, 32'h200};
    etg = '{32'h400, 32'h480, 32'h200}; hit = '{1'b0, 1'b1, 1'b1};
    jmp = '{1'b1, 1'b1, 1'b0};          tk  = '{1'b1, 1'b1, 1'b0};
    expP = '{1'b0, 1'b1, 1'b1};         expN = '{32'h304, 32'h400, 32'h200};
    bIdx = '{8'hC0, 8'hC0, 8'h40};      expBht = '{2'b11, 2'b11, 2'b10};
    expCnt = '{{32'd3, 32'd2}, {32'd4, 32'd3}, {32'd5, 32'd4}};
    sbq.push_back({1'b1, 32'h400, 1'b1, 32'h300, 32'h400});
    sbq.push_back({1'b1, 32'h480, 1'b1, 32'h300, 32'h480});
    sbq.push_back({1'b1, 32'h104, 1'b0, 32'h0, 32'h0});
    for (int i = 0; i < 3; i++) begin
      pipeInstr(fpc[i], hit[i], ftg[i], ~jmp[i], jmp[i], tk[i], etg[i], p, n);
      checks++;
      if ({p, n} !== {expP[i], expN[i]})
        begin errors++; $display("[TB] FAIL wrong_pred[%0d]: got %h expected %h", i, {p, n}, {expP[i], expN[i]}); end
      @(negedge clk);
      checks++; o = observe();
      if (sbq.size() == 0) begin errors++; $display("[TB] FAIL wrong_resolve[%0d]: got %h expected queued entry", i, o); end
      else begin e = sbq.pop_front(); if (o !== e) begin errors++; $display("[TB] FAIL wrong_resolve[%0d]: got %h expected %h", i, o, e); end end
      nextCycle();
      clearE();
      checks++;
      if (dut.bht_q[bIdx[i]] !== expBht[i])
        begin errors++; $display("[TB] FAIL wrong_bht[%0d]: got %b expected %b", i, dut.bht_q[bIdx[i]], expBht[i]); end
      checks++;
      if ({branch_cnt, mispred_cnt} !== expCnt[i])
        begin errors++; $display("[TB] FAIL wrong_counters[%0d]: got %h expected %h", i, {branch_cnt, mispred_cnt}, expCnt[i]); end
    end
  endtask

  task automatic test_stall_bubble();
    exp_t e, o;
    sbq.push_back({1'b0, 32'h400, 1'b1, 32'h300, 32'h400});
    pc_F = 32'h300; btb_hit_F = 1'b1; btb_target_F = 32'h400;
    @(negedge clk);
    checks++;
    if ({pred_taken_F, next_pc_F} !== {1'b1, 32'h400})
      begin errors++; $display("[TB] FAIL stall_pred: got %h expected %h", {pred_taken_F, next_pc_F}, {1'b1, 32'h400}); end
    nextCycle();
    pc_F = 32'h500; btb_hit_F = 1'b0; btb_target_F = 32'h999;
    stall_D = 1'b1; bubble_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin pc_E = 32'h500; branch_E = 1'b1; taken_E = 1'b1; target_E = 32'h600; end
      @(negedge clk);
      checks++;
      if ({dut.vD_q, dut.ptD_q, dut.tgtD_q} !== {1'b1, 1'b1, 32'h400})
        begin errors++; $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", i, {dut.vD_q, dut.ptD_q, dut.tgtD_q}, {1'b1, 1'b1, 32'h400}); end
      if (i > 0) begin
        checks++;
        if ({redirect, redirect_pc, btb_wr_en} !== 34'h0)
          begin errors++; $display("[TB] FAIL bubble_quiet[%0d]: got %h expected 0", i, {redirect, redirect_pc, btb_wr_en}); end
      end
      nextCycle();
    end
    checks++;
    if ({branch_cnt, mispred_cnt} !== {32'd5, 32'd4})
      begin errors++; $display("[TB] FAIL bubble_counters: got %h expected %h", {branch_cnt, mispred_cnt}, {32'd5, 32'd4}); end
    idleInputs();
    nextCycle();
    pc_E = 32'h300; jump_E = 1'b1; taken_E = 1'b1; target_E = 32'h400;
    @(negedge clk);
    checks++; o = observe();
    if (sbq.size() == 0) begin errors++; $display("[TB] FAIL stall_resolve: got %h expected queued entry", o); end
    else begin e = sbq.pop_front(); if (o !== e) begin errors++; $display("[TB] FAIL stall_resolve: got %h expected %h", o, e); end end
    nextCycle();
    clearE();
    checks++;
    if ({branch_cnt, mispred_cnt} !== {32'd6, 32'd4})
      begin errors++; $display("[TB] FAIL stall_counters: got %h expected %h", {branch_cnt, mispred_cnt}, {32'd6, 32'd4}); end
  endtask

  task automatic test_redirect_with_stall();
    logic p; logic [31:0] n; exp_t e, o;
    sbq.push_back({1'b1, 32'h200, 1'b1, 32'h100, 32'h200});
    pipeInstr(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200, p, n);
    stall_D = 1'b1;
    @(negedge clk);
    checks++; o = observe();
    if (sbq.size() == 0) begin errors++; $display("[TB] FAIL rs_resolve: got %h expected queued entry", o); end
    else begin e = sbq.pop_front(); if (o !== e) begin errors++; $display("[TB] FAIL rs_resolve: got %h expected %h", o, e); end end
    nextCycle();
    stall_D = 1'b0;
    clearE();
    checks++;
    if ({dut.vD_q, dut.vE_q} !== 2'b00)
      begin errors++; $display("[TB] FAIL rs_flush: got %b expected 00", {dut.vD_q, dut.vE_q}); end
    checks++;
    if (dut.bht_q[8'h40] !== 2'b11)
      begin errors++; $display("[TB] FAIL rs_bht: got %b expected 11", dut.bht_q[8'h40]); end
    checks++;
    if ({branch_cnt, mispred_cnt} !== {32'd7, 32'd5})
      begin errors++; $display("[TB] FAIL rs_counters: got %h expected %h", {branch_cnt, mispred_cnt}, {32'd7, 32'd5}); end
  endtask

  task automatic test_saturation();
    logic p; logic [31:0] n; exp_t e, o;
    logic [1:0] expBht [9];
    logic       tk [9];
    expBht = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    tk     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      if (tk[i]) sbq.push_back({1'b1, 32'h640, 1'b1, 32'h600, 32'h640});
      else       sbq.push_back({1'b0, 32'h604, 1'b0, 32'h0, 32'h0});
      pipeInstr(32'h600, 1'b0, 32'h0, 1'b1, 1'b0, tk[i], 32'h640, p, n);
      @(negedge clk);
      checks++; o = observe();
      if (sbq.size() == 0) begin errors++; $display("[TB] FAIL sat_resolve[%0d]: got %h expected queued entry", i, o); end
      else begin e = sbq.pop_front(); if (o !== e) begin errors++; $display("[TB] FAIL sat_resolve[%0d]: got %h expected %h", i, o, e); end end
      nextCycle();
      clearE();
      checks++;
      if (dut.bht_q[8'h80] !== expBht[i])
        begin errors++; $display("[TB] FAIL sat_bht[%0d]: got %b expected %b", i, dut.bht_q[8'h80], expBht[i]); end
    end
    checks++;
    if ({branch_cnt, mispred_cnt} !== {32'd16, 32'd9})
      begin errors++; $display("[TB] FAIL sat_counters: got %h expected %h", {branch_cnt, mispred_cnt}, {32'd16, 32'd9}); end
  endtask

  task automatic test_counter_saturation();
    logic p; logic [31:0] n; exp_t e, o;
    force dut.mispredCnt_q = 32'hFFFF_FFFE;
    force dut.branchCnt_q  = 32'hFFFF_FFFF;
    #1;
    release dut.mispredCnt_q;
    release dut.branchCnt_q;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back({1'b1, 32'hA00, 1'b1, 32'h900, 32'hA00});
      pipeInstr(32'h900, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA00, p, n);
      @(negedge clk);
      checks++; o = observe();
      if (sbq.size() == 0) begin errors++; $display("[TB] FAIL csat_resolve[%0d]: got %h expected queued entry", i, o); end
      else begin e = sbq.pop_front(); if (o !== e) begin errors++; $display("[TB] FAIL csat_resolve[%0d]: got %h expected %h", i, o, e); end end
      nextCycle();
      clearE();
      checks++;
      if ({branch_cnt, mispred_cnt} !== 64'hFFFF_FFFF_FFFF_FFFF)
        begin errors++; $display("[TB] FAIL csat_counters[%0d]: got %h expected all ones", i, {branch_cnt, mispred_cnt}); end
    end
  endtask

  task automatic test_reset_midresolve();
    logic p; logic [31:0] n; exp_t e, o;
    sbq.push_back({1'b1, 32'h300, 1'b1, 32'h100, 32'h300});
    pipeInstr(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h300, p, n);
    #1;
    checks++; o = observe();
    if (sbq.size() == 0) begin errors++; $display("[TB] FAIL mid_resolve: got %h expected queued entry", o); end
    else begin e = sbq.pop_front(); if (o !== e) begin errors++; $display("[TB] FAIL mid_resolve: got %h expected %h", o, e); end end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({redirect, redirect_pc, btb_wr_en} !== 34'h0)
      begin errors++; $display("[TB] FAIL async_resolve: got %h expected 0", {redirect, redirect_pc, btb_wr_en}); end
    checks++;
    if ({branch_cnt, mispred_cnt} !== 64'h0)
      begin errors++; $display("[TB] FAIL async_counters: got %h expected 0", {branch_cnt, mispred_cnt}); end
    checks++;
    if ({dut.bht_q[8'h40], dut.bht_q[8'hC0], dut.bht_q[8'h80]} !== 6'b010101)
      begin errors++; $display("[TB] FAIL async_bht: got %b expected 010101", {dut.bht_q[8'h40], dut.bht_q[8'hC0], dut.bht_q[8'h80]}); end
    clearE();
    pc_F = 32'h100; btb_hit_F = 1'b1; btb_target_F = 32'h200;
    #1;
    checks++;
    if (pred_taken_F !== 1'b0)
      begin errors++; $display("[TB] FAIL async_pred: got %b expected 0", pred_taken_F); end
    @(negedge clk);
    rst_n = 1'b1;
    pc_F = 32'h300; btb_target_F = 32'h400;
    #1;
    checks++;
    if ({pred_taken_F, next_pc_F} !== {1'b0, 32'h304})
      begin errors++; $display("[TB] FAIL post_async_pred: got %h expected %h", {pred_taken_F, next_pc_F}, {1'b0, 32'h304}); end
    idleInputs();
    nextCycle();
  endtask

  initial begin
    $display("[TB] branch_resolve_unit bench start");
    test_reset();
    test_cold_branch();
    test_warm_hit();
    test_wrong_target();
    test_stall_bubble();
    test_redirect_with_stall();
    test_saturation();
    test_counter_saturation();
    test_reset_midresolve();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
